// File: rtl/msg_streamer.sv
// rtl/msg_streamer.sv - streams a fixed ROM message one character at a time over valid/ready
//
// Walks ROM indices 0..MSG_LEN-1, fetching each byte and presenting it to a sink
// until accepted. A pass ends on the last index or when the TERM byte is fetched.
// With loop=1 at pass end the walk restarts at index 0; otherwise done pulses.
//
// Optional build macro: MSG_STREAMER_SKIP_SPACE_EN - space bytes (8'h20) are
// skipped in FETCH instead of being presented.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   start      in   begin a pass (honoured in IDLE only)
//   loop       in   restart at index 0 after a pass (sampled at pass end)
//   rom_addr   out  registered ROM address (current index)
//   rom_data   in   combinational ROM read data for rom_addr
//   char_data  out  registered character being presented
//   char_valid out  char_data valid, held until char_ready
//   char_ready in   sink accept
//   busy       out  high outside IDLE
//   done       out  one-cycle pulse at end of a non-looping pass

module msg_streamer #(
    parameter int               ADDR_W  = 4,
    parameter int               DATA_W  = 8,
    parameter int               MSG_LEN = 12,
    parameter logic [DATA_W-1:0] TERM   = 8'h00
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              loop,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] char_data,
    output logic              char_valid,
    input  logic              char_ready,
    output logic              busy,
    output logic              done
);

`ifdef MSG_STREAMER_SKIP_SPACE_EN
    localparam bit SKIP_SPACE = 1'b1;
`else
    localparam bit SKIP_SPACE = 1'b0;
`endif

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
    localparam logic [DATA_W-1:0] SPACE    = DATA_W'(8'h20);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_PRESENT,
        S_END
    } state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] index, index_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    // The index register drives the ROM directly, so rom_addr is always registered
    // and never moves while a character is being presented.
    assign rom_addr   = index;
    assign char_data  = data_q;
    assign char_valid = valid_q;
    assign busy       = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            index   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            index   <= index_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        index_d = index;
        data_d  = data_q;
        valid_d = valid_q;
        done    = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    index_d = '0;
                    state_d = S_FETCH;
                end
            end

            S_FETCH: begin
                if (rom_data == TERM) begin
                    state_d = S_END;
                end else if (SKIP_SPACE && (rom_data == SPACE)) begin
                    // Skipped bytes consume an index but no handshake.
                    if (index == LAST_IDX) begin
                        state_d = S_END;
                    end else begin
                        index_d = index + ADDR_W'(1);
                    end
                end else begin
                    data_d  = rom_data;
                    valid_d = 1'b1;
                    state_d = S_PRESENT;
                end
            end

            S_PRESENT: begin
                // char_valid is always high here, so char_ready alone completes the handshake.
                if (char_ready) begin
                    valid_d = 1'b0;
                    if (index == LAST_IDX) begin
                        state_d = S_END;
                    end else begin
                        index_d = index + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
            end

            S_END: begin
                if (loop) begin
                    index_d = '0;
                    state_d = S_FETCH;
                end else begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_msg_streamer.sv
// tb/tb_msg_streamer.sv - randomized self-checking bench for msg_streamer against a message model

module tb_msg_streamer;

`ifdef MSG_STREAMER_SKIP_SPACE_EN
    localparam bit SKIP_SPACE = 1'b1;
`else
    localparam bit SKIP_SPACE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       loop;
    logic       char_ready;

    logic [3:0] addr_a, addr_b;
    logic [7:0] rdata_a, rdata_b;
    logic [7:0] data_a, data_b;
    logic       valid_a, valid_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    logic [7:0] rom_a [0:15];
    logic [7:0] rom_b [0:15];

    assign rdata_a = rom_a[addr_a];
    assign rdata_b = rom_b[addr_b];

    msg_streamer #(.ADDR_W(4), .DATA_W(8), .MSG_LEN(12), .TERM(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .loop(loop),
        .rom_addr(addr_a), .rom_data(rdata_a),
        .char_data(data_a), .char_valid(valid_a), .char_ready(char_ready),
        .busy(busy_a), .done(done_a)
    );

    msg_streamer #(.ADDR_W(4), .DATA_W(8), .MSG_LEN(16), .TERM(8'h00)) dut16 (
        .clk(clk), .rst(rst), .start(start), .loop(loop),
        .rom_addr(addr_b), .rom_data(rdata_b),
        .char_data(data_b), .char_valid(valid_b), .char_ready(char_ready),
        .busy(busy_b), .done(done_b)
    );

    int sel;
    logic [3:0] cur_addr;
    logic [7:0] cur_data;
    logic       cur_valid, cur_busy, cur_done;
    assign cur_addr  = (sel != 0) ? addr_b  : addr_a;
    assign cur_data  = (sel != 0) ? data_b  : data_a;
    assign cur_valid = (sel != 0) ? valid_b : valid_a;
    assign cur_busy  = (sel != 0) ? busy_b  : busy_a;
    assign cur_done  = (sel != 0) ? done_b  : done_a;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] got [$];
    logic [7:0] exp_q [$];
    int  done_cnt, done_cyc, first_v, s_cyc;
    logic [3:0] max_addr;
    bit  prev_hold;
    logic [7:0] prev_data;

    localparam logic [7:0] MSG [0:11] = '{8'h45, 8'h4E, 8'h47, 8'h49, 8'h4E, 8'h45,
                                          8'h45, 8'h52, 8'h49, 8'h4E, 8'h47, 8'h20};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        checks++;
        if (obs !== req) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Observer: records accepted characters and done pulses, and checks that a
    // presented character is held unchanged until the sink takes it.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            prev_hold = 1'b0;
        end else begin
            if (cur_valid && first_v < 0) first_v = cyc;
            if (cur_valid && char_ready) got.push_back(cur_data);
            if (cur_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (cur_busy && cur_addr > max_addr) max_addr = cur_addr;
            if (prev_hold) begin
                check("hold_valid", {31'd0, cur_valid}, 32'd1);
                check("hold_data", {24'd0, cur_data}, {24'd0, prev_data});
            end
            prev_hold = cur_valid && !char_ready;
            prev_data = cur_data;
        end
    end

    // Expected character list: walk the ROM, stop at the terminator, drop spaces
    // when the skip build is selected.
    function automatic void build_exp(input int which, input int len);
        logic [7:0] b;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            b = (which != 0) ? rom_b[i] : rom_a[i];
            if (b == 8'h00) break;
            if (SKIP_SPACE && b == 8'h20) continue;
            exp_q.push_back(b);
        end
    endfunction

    task automatic clear_mon();
        got.delete();
        done_cnt = 0;
        done_cyc = 0;
        first_v  = -1;
        max_addr = 4'd0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        s_cyc = cyc;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // mode 0: ready always high; 1: random ready; 2: stall 5 cycles on index 3
    task automatic drive_ready(input int mode, inout int stall);
        if (mode == 0) char_ready = 1'b1;
        else if (mode == 1) char_ready = ($urandom_range(0, 99) < 60);
        else if (cur_valid && cur_addr == 4'd3 && stall < 5) begin
            char_ready = 1'b0;
            stall++;
        end else char_ready = 1'b1;
    endtask

    task automatic wait_done(input string tag, input int mode, input int limit);
        int stall = 0;
        for (int k = 0; k < limit && done_cnt == 0; k++) begin
            drive_ready(mode, stall);
            @(posedge clk);
            #1;
        end
        check({tag, "_done_seen"}, {31'd0, done_cnt > 0}, 32'd1);
    endtask

    task automatic finish_pass(input string tag, input int reps);
        int n;
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_once"}, done_cnt, 32'd1);
        check({tag, "_busy_low"}, {31'd0, cur_busy}, 32'd0);
        n = exp_q.size() * reps;
        check({tag, "_count"}, got.size(), n);
        for (int i = 0; i < got.size() && i < n; i++)
            check({tag, "_char"}, {24'd0, got[i]}, {24'd0, exp_q[i % exp_q.size()]});
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  {28'd0, addr_a}, 32'd0);
        check({tag, "_data"},  {24'd0, data_a}, 32'd0);
        check({tag, "_valid"}, {31'd0, valid_a}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy_a}, 32'd0);
        check({tag, "_done"},  {31'd0, done_a}, 32'd0);
    endtask

    initial begin
        int d;
        bit hit;
        rst = 1'b1; start = 1'b0; loop = 1'b0; char_ready = 1'b0; sel = 0;
        for (int i = 0; i < 16; i++) begin
            rom_a[i] = (i < 12) ? MSG[i] : 8'hFF;
            rom_b[i] = (i < 12) ? MSG[i] : 8'h00;
        end
        clear_mon();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("reset");

        // Single pass, full throughput, latency of first character and done.
        sel = 0; build_exp(0, 12); clear_mon(); char_ready = 1'b1;
        pulse_start();
        wait_done("single", 0, 200);
        d = done_cyc - s_cyc;
        check("single_first_lat", first_v - s_cyc, 32'd2);
        check("single_done_lat", {31'd0, d >= 24 && d <= 25}, 32'd1);
        finish_pass("single", 1);

        // Backpressure on index 3.
        do_reset(); clear_mon(); build_exp(0, 12);
        pulse_start();
        wait_done("stall", 2, 300);
        finish_pass("stall", 1);

        // Terminator after index 11 on the 16-entry instance.
        do_reset(); sel = 1; clear_mon(); build_exp(1, 16); char_ready = 1'b1;
        pulse_start();
        wait_done("term", 0, 300);
        check("term_max_addr", {31'd0, max_addr <= 4'd12}, 32'd1);
        finish_pass("term", 1);

        // Loop into a second pass, then drop loop mid-pass.
        do_reset(); sel = 0; clear_mon(); build_exp(0, 12); loop = 1'b1; char_ready = 1'b1;
        pulse_start();
        for (int k = 0; k < 200 && got.size() < exp_q.size() + 2; k++) begin
            @(posedge clk);
            #1;
        end
        check("loop_reached", {31'd0, got.size() >= exp_q.size() + 2}, 32'd1);
        check("loop_no_done", done_cnt, 32'd0);
        if (got.size() > exp_q.size())
            check("loop_restart_char", {24'd0, got[exp_q.size()]}, {24'd0, exp_q[0]});
        loop = 1'b0;
        wait_done("loop", 0, 200);
        finish_pass("loop", 2);

        // Reset while a character at index 5 is being presented.
        do_reset(); clear_mon(); char_ready = 1'b1;
        pulse_start();
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            if (valid_a && addr_a == 4'd5) begin
                char_ready = 1'b0;
                hit = 1'b1;
            end else begin
                @(posedge clk);
                #1;
            end
        end
        check("rstmid_reached", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check_reset_outputs("rstmid");

        // Extra start while busy must not disturb the pass.
        clear_mon(); build_exp(0, 12);
        pulse_start();
        char_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("busy_during_pass", {31'd0, busy_a}, 32'd1);
        pulse_start();
        wait_done("busystart", 1, 400);
        finish_pass("busystart", 1);

        // Random ROM contents and random backpressure on both instances.
        for (int t = 0; t < 8; t++) begin
            do_reset();
            sel = t % 2;
            for (int i = 0; i < 16; i++) begin
                logic [7:0] b;
                b = 8'($urandom_range(1, 255));
                if ($urandom_range(0, 7) == 0) b = 8'h20;
                if ($urandom_range(0, 13) == 0) b = 8'h00;
                if (sel != 0) rom_b[i] = b;
                else rom_a[i] = b;
            end
            clear_mon();
            build_exp(sel, (sel != 0) ? 16 : 12);
            pulse_start();
            wait_done("rand", 1, 600);
            finish_pass("rand", 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
